// File: rtl/enc_stream_secded_if.sv
// Stream bundle for the SECDED encoder: upstream word port, downstream codeword port and
// the dropped-word counter.
interface enc_stream_secded_if #(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26,
  parameter int unsigned ERR_CNT_WIDTH      = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [MAX_INFO_WIDTH-1:0]     data_in;
  logic [1:0]                    mod;
  logic                          out_valid;
  logic                          out_ready;
  logic [MAX_CODEWORD_WIDTH-1:0] data_out;
  logic [1:0]                    out_mod;
  logic [ERR_CNT_WIDTH-1:0]      err_cnt;

  modport master (
    output in_valid, data_in, mod, out_ready,
    input  in_ready, out_valid, data_out, out_mod, err_cnt
  );

  modport slave (
    input  in_valid, data_in, mod, out_ready,
    output in_ready, out_valid, data_out, out_mod, err_cnt
  );
endinterface

// File: rtl/enc_stream_secded.sv
// Two-stage streaming extended-Hamming (SECDED) encoder, three codeword sizes selected per word.
// Illegal-mode words are consumed, dropped and counted.
module enc_stream_secded #(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26,
  parameter int unsigned ERR_CNT_WIDTH      = 8
) (
  input  logic               clk,
  input  logic               rst,
  enc_stream_secded_if.slave bus
);

  localparam int unsigned NumHamPar = 5;

  typedef logic [MAX_INFO_WIDTH-1:0]     info_t;
  typedef logic [MAX_CODEWORD_WIDTH-1:0] code_t;

  // Info bit i sits at the i-th non-power-of-two position; mask bit i is that position's bit j.
  function automatic info_t par_mask(int unsigned j);
    info_t       m;
    int unsigned idx;
    m   = '0;
    idx = 0;
    for (int unsigned pos = 3; pos < 64; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (idx < MAX_INFO_WIDTH && ((pos >> j) & 1) != 0) begin
          m |= info_t'(1) << idx;
        end
        idx++;
      end
    end
    return m;
  endfunction

  logic                     rdy_en_q;
  logic                     s1_v_q;
  info_t                    s1_info_q;
  logic [1:0]               s1_mod_q;
  logic [NumHamPar-1:0]     s1_par_q;
  logic                     s2_v_q;
  code_t                    s2_code_q;
  logic [1:0]               s2_mod_q;
  logic [ERR_CNT_WIDTH-1:0] err_q;

  logic                 adv1, adv2, in_ready, accept, take, drop;
  info_t                info_mask, info_masked;
  logic [NumHamPar-1:0] par;
  logic                 overall;
  code_t                code_d;

  always_comb begin
    adv2     = !s2_v_q || bus.out_ready;
    adv1     = !s1_v_q || adv2;
    // rdy_en_q keeps in_ready low while reset is applied.
    in_ready = rdy_en_q && adv1;
    accept   = bus.in_valid && in_ready;
    take     = accept && (bus.mod != 2'b00);
    drop     = accept && (bus.mod == 2'b00);
  end

  always_comb begin
    info_mask = '0;
    case (bus.mod)
      2'b01:   info_mask = {{(MAX_INFO_WIDTH - 4){1'b0}}, 4'hF};
      2'b10:   info_mask = {{(MAX_INFO_WIDTH - 11){1'b0}}, 11'h7FF};
      2'b11:   info_mask = '1;
      default: info_mask = '0;
    endcase
    info_masked = bus.data_in & info_mask;
  end

  // Smaller modes never reach the upper positions, so their unused parity bits come out 0.
  for (genvar j = 0; j < NumHamPar; j++) begin : g_par
    localparam info_t Mask = par_mask(j);
    assign par[j] = ^(info_masked & Mask);
  end

  always_comb begin
    overall = (^s1_info_q) ^ (^s1_par_q);
    code_d  = '0;
    case (s1_mod_q)
      2'b01:   code_d[7:0]  = {overall, s1_par_q[2:0], s1_info_q[3:0]};
      2'b10:   code_d[15:0] = {overall, s1_par_q[3:0], s1_info_q[10:0]};
      default: code_d[31:0] = {overall, s1_par_q[4:0], s1_info_q[25:0]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q  <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_info_q <= '0;
      s1_mod_q  <= 2'b00;
      s1_par_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_code_q <= '0;
      s2_mod_q  <= 2'b00;
      err_q     <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (adv1) begin
        s1_v_q <= take;
      end
      if (take) begin
        s1_info_q <= info_masked;
        s1_mod_q  <= bus.mod;
        s1_par_q  <= par;
      end
      if (adv2) begin
        s2_v_q <= s1_v_q;
      end
      if (adv2 && s1_v_q) begin
        s2_code_q <= code_d;
        s2_mod_q  <= s1_mod_q;
      end
      if (drop && err_q != '1) begin
        err_q <= err_q + ERR_CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_v_q;
  assign bus.data_out  = s2_code_q;
  assign bus.out_mod   = s2_mod_q;
  assign bus.err_cnt   = err_q;

endmodule
